const_level_monitor: RTL and testbench



---
 rtl/const_level_pkg.sv | 14 +
 rtl/level_debounce_bit.sv | 101 ++++++++++
 rtl/const_level_monitor.sv | 74 +++++++
 tb/tb_const_level_monitor.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/const_level_pkg.sv
// Shared types and default parameter values for the level monitor.
package const_level_pkg;

    typedef enum logic {
        STABLE  = 1'b0,
        PENDING = 1'b1
    } deb_state_t;

    localparam int unsigned DEF_WIDTH      = 4;
    localparam int unsigned DEF_DEB_CYCLES = 15;
    localparam int unsigned DEF_CNT_W      = 4;
    localparam int unsigned DEF_GLITCH_W   = 8;

endpackage

// File: rtl/level_debounce_bit.sv
// One monitored bit: 2-flop synchronizer, debounce FSM, level register and
// edge pulses. Reports a glitch strobe and a pending flag to the top level.
module level_debounce_bit
    import const_level_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = DEF_DEB_CYCLES,
    parameter int unsigned CNT_W      = DEF_CNT_W,
    parameter logic        RESET_BIT  = 1'b0
) (
    input  logic clk,
    input  logic resetn,
    input  logic in_async,
    output logic level,
    output logic rise_pulse,
    output logic fall_pulse,
    output logic glitch,
    output logic pending
);

    logic             sync1;
    logic             sync2;
    deb_state_t       state;
    deb_state_t       state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             flip;

    // Two-stage synchronizer; only sync2 feeds the debounce logic.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1 <= RESET_BIT;
            sync2 <= RESET_BIT;
        end else begin
            sync1 <= in_async;
            sync2 <= sync1;
        end
    end

    // State register plus the level and pulse registers that move with it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= STABLE;
            cnt        <= '0;
            level      <= RESET_BIT;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            level      <= level ^ flip;
            rise_pulse <= flip & ~level;
            fall_pulse <= flip & level;
        end
    end

    // Next-state: count consecutive differing samples, flip on the last one.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        flip       = 1'b0;
        case (state)
            STABLE: begin
                if (sync2 != level) begin
                    if (DEB_CYCLES == 1) begin
                        flip = 1'b1;
                    end else begin
                        state_next = PENDING;
                        cnt_next   = CNT_W'(1);
                    end
                end else begin
                    cnt_next = '0;
                end
            end
            PENDING: begin
                if (sync2 != level) begin
                    if (cnt == CNT_W'(DEB_CYCLES - 1)) begin
                        flip       = 1'b1;
                        state_next = STABLE;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end else begin
                    state_next = STABLE;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = STABLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Status outputs: a glitch is a pending count abandoned by a matching sample.
    always_comb begin
        pending = (state == PENDING);
        glitch  = (state == PENDING) && (sync2 == level);
    end

endmodule

// File: rtl/const_level_monitor.sv
// Synchronizes and debounces WIDTH asynchronous level inputs, reporting clean
// levels, edge pulses, a saturating glitch count and a sticky mismatch flag.
module const_level_monitor
    import const_level_pkg::*;
#(
    parameter int unsigned       WIDTH       = DEF_WIDTH,
    parameter int unsigned       DEB_CYCLES  = DEF_DEB_CYCLES,
    parameter int unsigned       CNT_W       = DEF_CNT_W,
    parameter int unsigned       GLITCH_W    = DEF_GLITCH_W,
    parameter logic [WIDTH-1:0]  RESET_LEVEL = '0
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [WIDTH-1:0]    in_async,
    input  logic [WIDTH-1:0]    expected,
    input  logic                check_en,
    input  logic                clear,
    output logic [WIDTH-1:0]    level_out,
    output logic [WIDTH-1:0]    rise_pulse,
    output logic [WIDTH-1:0]    fall_pulse,
    output logic                settled,
    output logic                mismatch,
    output logic [GLITCH_W-1:0] glitch_cnt
);

    logic [WIDTH-1:0] glitch_vec;
    logic [WIDTH-1:0] pending_vec;
    logic             any_glitch;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        level_debounce_bit #(
            .DEB_CYCLES (DEB_CYCLES),
            .CNT_W      (CNT_W),
            .RESET_BIT  (RESET_LEVEL[i])
        ) u_bit (
            .clk        (clk),
            .resetn     (resetn),
            .in_async   (in_async[i]),
            .level      (level_out[i]),
            .rise_pulse (rise_pulse[i]),
            .fall_pulse (fall_pulse[i]),
            .glitch     (glitch_vec[i]),
            .pending    (pending_vec[i])
        );
    end

    // Aggregate per-bit status into block-level flags.
    always_comb begin
        any_glitch = |glitch_vec;
        settled    = ~|pending_vec;
    end

    // Glitch counter: clear first, then one saturating increment per glitching cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            glitch_cnt <= '0;
        end else if (clear) begin
            glitch_cnt <= any_glitch ? GLITCH_W'(1) : '0;
        end else if (any_glitch && (glitch_cnt != '1)) begin
            glitch_cnt <= glitch_cnt + GLITCH_W'(1);
        end
    end

    // Sticky mismatch; a new mismatch wins over a simultaneous clear.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mismatch <= 1'b0;
        end else begin
            mismatch <= (check_en && settled && (level_out != expected)) ||
                        (mismatch && !clear);
        end
    end

endmodule

// File: tb/tb_const_level_monitor.sv
// Scoreboard bench for const_level_monitor: the driver pushes the expected
// post-edge outputs from a run-length reference model, the monitor pops and
// compares after every rising edge.
module tb_const_level_monitor;

    localparam int DEB = 15;

    typedef struct {
        logic [3:0] level;
        logic [3:0] rise;
        logic [3:0] fall;
        logic       settled;
        logic       mis;
        int         gc;
    } exp_t;

    logic       clk;
    logic       resetn;
    logic [3:0] in_async;
    logic [3:0] expected;
    logic       check_en;
    logic       clear;
    logic [3:0] level_out;
    logic [3:0] rise_pulse;
    logic [3:0] fall_pulse;
    logic       settled;
    logic       mismatch;
    logic [7:0] glitch_cnt;

    int n_cmp = 0;
    int n_err = 0;

    exp_t q[$];

    // Reference model state: synchronizer pipe, levels, run lengths of
    // consecutive samples disagreeing with the level, sticky flag, count.
    logic [3:0] m_s1, m_s2, m_lvl;
    int         m_run[4];
    logic       m_mis;
    int         m_gc;

    // Staged values applied at the next falling edge.
    logic [3:0] nx_exp;
    logic       nx_chk;
    logic       nx_rn;

    const_level_monitor #(
        .WIDTH       (4),
        .DEB_CYCLES  (DEB),
        .CNT_W       (4),
        .GLITCH_W    (8),
        .RESET_LEVEL (4'b0000)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .in_async   (in_async),
        .expected   (expected),
        .check_en   (check_en),
        .clear      (clear),
        .level_out  (level_out),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .settled    (settled),
        .mismatch   (mismatch),
        .glitch_cnt (glitch_cnt)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, req);
        end
    endtask

    task automatic model_reset();
        m_s1  = '0;
        m_s2  = '0;
        m_lvl = '0;
        for (int b = 0; b < 4; b++) m_run[b] = 0;
        m_mis = 1'b0;
        m_gc  = 0;
    endtask

    // Advance the model across one rising edge with the inputs now applied.
    task automatic model_edge();
        exp_t       e;
        logic [3:0] nl;
        logic       anyg;
        logic       pre_settled;
        e.rise = '0;
        e.fall = '0;
        if (!resetn) begin
            model_reset();
        end else begin
            pre_settled = 1'b1;
            for (int b = 0; b < 4; b++) if (m_run[b] != 0) pre_settled = 1'b0;
            anyg = 1'b0;
            nl   = m_lvl;
            for (int b = 0; b < 4; b++) begin
                if (m_s2[b] != m_lvl[b]) begin
                    m_run[b]++;
                    if (m_run[b] == DEB) begin
                        nl[b]    = ~m_lvl[b];
                        m_run[b] = 0;
                        if (nl[b]) e.rise[b] = 1'b1;
                        else       e.fall[b] = 1'b1;
                    end
                end else begin
                    if (m_run[b] > 0) anyg = 1'b1;
                    m_run[b] = 0;
                end
            end
            m_mis = (check_en && pre_settled && (m_lvl != expected)) || (m_mis && !clear);
            if (clear) m_gc = 0;
            if (anyg && m_gc < 255) m_gc++;
            m_s2  = m_s1;
            m_s1  = in_async;
            m_lvl = nl;
        end
        e.level   = m_lvl;
        e.settled = 1'b1;
        for (int b = 0; b < 4; b++) if (m_run[b] != 0) e.settled = 1'b0;
        e.mis = m_mis;
        e.gc  = m_gc;
        q.push_back(e);
    endtask

    // One clock of stimulus: apply inputs at the falling edge, then predict.
    task automatic cyc(input logic [3:0] iv, input logic cl = 1'b0);
        logic prev_rn;
        @(negedge clk);
        prev_rn  = resetn;
        in_async = iv;
        clear    = cl;
        expected = nx_exp;
        check_en = nx_chk;
        resetn   = nx_rn;
        if (prev_rn && !resetn) begin
            #1;
            chk("async_rst_level", 32'(level_out), 32'(0));
            chk("async_rst_rise", 32'(rise_pulse), 32'(0));
            chk("async_rst_fall", 32'(fall_pulse), 32'(0));
            chk("async_rst_settled", 32'(settled), 32'(1));
            chk("async_rst_mismatch", 32'(mismatch), 32'(0));
            chk("async_rst_glitch_cnt", 32'(glitch_cnt), 32'(0));
        end
        model_edge();
    endtask

    task automatic pulse_reset(input logic [3:0] iv);
        nx_rn = 1'b0;
        cyc(iv);
        cyc(iv);
        nx_rn = 1'b1;
    endtask

    // Monitor: compare every registered output shortly after each rising edge.
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("level_out", 32'(level_out), 32'(e.level));
            chk("rise_pulse", 32'(rise_pulse), 32'(e.rise));
            chk("fall_pulse", 32'(fall_pulse), 32'(e.fall));
            chk("settled", 32'(settled), 32'(e.settled));
            chk("mismatch", 32'(mismatch), 32'(e.mis));
            chk("glitch_cnt", 32'(glitch_cnt), 32'(e.gc));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] v;
        int         len;
        resetn   = 1'b0;
        in_async = '0;
        expected = '0;
        check_en = 1'b0;
        clear    = 1'b0;
        nx_exp   = '0;
        nx_chk   = 1'b0;
        nx_rn    = 1'b0;
        model_reset();

        // Reset, then release with all inputs low.
        repeat (3) cyc(4'b0000);
        nx_rn = 1'b1;
        repeat (4) cyc(4'b0000);

        // Bit 0 raised and held through the full debounce.
        repeat (20) cyc(4'b0001);

        // Bit 1 short pulse: rejected, counted as a glitch.
        repeat (5) cyc(4'b0011);
        repeat (5) cyc(4'b0001);

        // Bits 2 and 3 glitching together until the counter saturates.
        for (int g = 0; g < 300; g++) begin
            len = $urandom_range(1, 5);
            repeat (len) cyc(4'b1101);
            cyc(4'b0001);
        end
        repeat (3) cyc(4'b0001);

        // Sticky mismatch, correction, clear, and clear while still mismatched.
        nx_exp = 4'b1111;
        nx_chk = 1'b1;
        repeat (3) cyc(4'b0001);
        nx_exp = 4'b0001;
        repeat (3) cyc(4'b0001);
        cyc(4'b0001, 1'b1);
        repeat (2) cyc(4'b0001);
        nx_exp = 4'b1111;
        repeat (2) cyc(4'b0001);
        cyc(4'b0001, 1'b1);
        repeat (2) cyc(4'b0001);
        nx_chk = 1'b0;
        cyc(4'b0001, 1'b1);

        // Reset in the middle of a rising debounce, then restart.
        repeat (20) cyc(4'b0000);
        repeat (9) cyc(4'b0001);
        pulse_reset(4'b0001);
        repeat (20) cyc(4'b0001);

        // Randomized segments with occasional clear, checks and resets.
        for (int s = 0; s < 80; s++) begin
            v      = 4'($urandom);
            len    = $urandom_range(1, 25);
            nx_chk = 1'($urandom_range(0, 1));
            nx_exp = ($urandom_range(0, 3) == 0) ? 4'($urandom) : m_lvl;
            if ($urandom_range(0, 19) == 0) pulse_reset(v);
            repeat (len) cyc(v, ($urandom_range(0, 15) == 0));
        end

        @(posedge clk);
        #2;
        if (q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
